// File: rtl/demux_stream_1x4.sv
// Registered 1-to-4 stream demultiplexer: one valid/ready input steered to four
// single-entry output channels, by explicit select or a round-robin pointer.
module demux_stream_1x4 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 rr_en,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [1:0]           rr_ptr
);

  // Handshake: a word transfers on any rising edge where valid && ready on the
  // same interface; ready never depends on valid, and a held word stays stable
  // until its consumer's ready is seen high.

  logic [4*WIDTH-1:0] out_data_q, out_data_d;
  logic [3:0]         out_valid_q, out_valid_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         target;
  logic               accept;

  always_comb begin
    target      = rr_en ? rr_ptr_q : in_sel;
    in_ready    = !out_valid_q[target] || out_ready[target];
    accept      = in_valid && in_ready;
    // Every channel drains on its own; a fill below overrides the target's drain.
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d[target]                 = 1'b1;
      out_data_d[target*WIDTH +: WIDTH]   = in_data;
      if (rr_en) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demux_stream_1x4.sv
// Directed bench for demux_stream_1x4: reset, explicit routing, round-robin
// wrap, back-pressure, channel independence and mode switching.
module tb_demux_stream_1x4;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic               rr_en;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [1:0]         rr_ptr;

  int total;
  int bad;
  logic [WIDTH-1:0] exp_q[$];

  demux_stream_1x4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rr_en = 1'b0; out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h3C;
    step();
    total++;
    if (out_valid !== 4'b0010) begin
      bad++; $display("FAIL reset_preload out_valid got=%b exp=%b", out_valid, 4'b0010);
    end
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h99;
    step();
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL reset_valid got=%b exp=0000", out_valid);
    end
    total++;
    if (out_data !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=00000000", out_data);
    end
    total++;
    if (rr_ptr !== 2'd0) begin
      bad++; $display("FAIL reset_ptr got=%0d exp=0", rr_ptr);
    end
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_explicit();
    rr_en = 1'b0; out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_data = 8'hA0 + 8'(i);
      step();
      total++;
      if (out_valid !== 4'(1 << i)) begin
        bad++; $display("FAIL explicit_valid ch=%0d got=%b exp=%b", i, out_valid, 4'(1 << i));
      end
      total++;
      if (out_data[i*WIDTH +: WIDTH] !== 8'hA0 + 8'(i)) begin
        bad++; $display("FAIL explicit_data ch=%0d got=%h exp=%h", i,
                        out_data[i*WIDTH +: WIDTH], 8'hA0 + 8'(i));
      end
      total++;
      if (rr_ptr !== 2'd0) begin
        bad++; $display("FAIL explicit_ptr got=%0d exp=0", rr_ptr);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL explicit_pulse got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_rr_wrap();
    logic [WIDTH-1:0] exp_w;
    int ch;
    rr_en = 1'b1; out_ready = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(k); in_sel = 2'(3 - (k % 4));
      exp_q.push_back(8'h10 + 8'(k));
      step();
      ch = k % 4;
      exp_w = exp_q.pop_front();
      total++;
      if (out_valid !== 4'(1 << ch)) begin
        bad++; $display("FAIL rr_valid k=%0d got=%b exp=%b", k, out_valid, 4'(1 << ch));
      end
      total++;
      if (out_data[ch*WIDTH +: WIDTH] !== exp_w) begin
        bad++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, out_data[ch*WIDTH +: WIDTH], exp_w);
      end
    end
    in_valid = 1'b0;
    total++;
    if (rr_ptr !== 2'd2) begin
      bad++; $display("FAIL rr_ptr_end got=%0d exp=2", rr_ptr);
    end
    step();
    total++;
    if (rr_ptr !== 2'd2) begin
      bad++; $display("FAIL rr_ptr_idle got=%0d exp=2", rr_ptr);
    end
  endtask

  task automatic test_back_pressure();
    rr_en = 1'b0; out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h55;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ready_empty got=%b exp=1", in_ready);
    end
    step();
    in_data = 8'h66;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (out_valid[2] !== 1'b1 || out_data[2*WIDTH +: WIDTH] !== 8'h55) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/55", c,
                        out_valid[2], out_data[2*WIDTH +: WIDTH]);
      end
    end
    out_ready = 4'b1111;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ready_drain got=%b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 4'b0100 || out_data[2*WIDTH +: WIDTH] !== 8'h66) begin
      bad++; $display("FAIL bp_drain_fill got=%b/%h exp=0100/66", out_valid,
                      out_data[2*WIDTH +: WIDTH]);
    end
    step();
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL bp_empty got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_independence();
    int ch;
    rr_en = 1'b0; out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77;
    step();
    for (int k = 0; k < 6; k++) begin
      ch = (k % 2 == 0) ? 0 : 3;
      in_sel = 2'(ch); in_data = 8'h80 + 8'(k);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL ind_ready k=%0d got=%b exp=1", k, in_ready);
      end
      step();
      total++;
      if (out_valid !== (4'(1 << ch) | 4'b0010)) begin
        bad++; $display("FAIL ind_valid k=%0d got=%b exp=%b", k, out_valid, 4'(1 << ch) | 4'b0010);
      end
      total++;
      if (out_data[ch*WIDTH +: WIDTH] !== 8'h80 + 8'(k) || out_data[WIDTH +: WIDTH] !== 8'h77) begin
        bad++; $display("FAIL ind_data k=%0d got=%h/%h exp=%h/77", k,
                        out_data[ch*WIDTH +: WIDTH], out_data[WIDTH +: WIDTH], 8'h80 + 8'(k));
      end
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    step();
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL ind_release got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    out_ready = 4'b1111; rr_en = 1'b1; in_valid = 1'b1; in_sel = 2'd3;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'h20 + 8'(k);
      step();
      total++;
      if (out_valid !== 4'(1 << k) || out_data[k*WIDTH +: WIDTH] !== 8'h20 + 8'(k)) begin
        bad++; $display("FAIL ms_rr k=%0d got=%b/%h exp=%b/%h", k, out_valid,
                        out_data[k*WIDTH +: WIDTH], 4'(1 << k), 8'h20 + 8'(k));
      end
    end
    total++;
    if (rr_ptr !== 2'd3) begin
      bad++; $display("FAIL ms_ptr3 got=%0d exp=3", rr_ptr);
    end
    rr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_sel = 2'(k); in_data = 8'h30 + 8'(k);
      step();
      total++;
      if (out_valid !== 4'(1 << k) || rr_ptr !== 2'd3) begin
        bad++; $display("FAIL ms_explicit k=%0d got=%b/%0d exp=%b/3", k, out_valid, rr_ptr, 4'(1 << k));
      end
    end
    rr_en = 1'b1; in_sel = 2'd1; in_data = 8'h40;
    step();
    total++;
    if (out_valid !== 4'b1000 || out_data[3*WIDTH +: WIDTH] !== 8'h40 || rr_ptr !== 2'd0) begin
      bad++; $display("FAIL ms_resume got=%b/%h/%0d exp=1000/40/0", out_valid,
                      out_data[3*WIDTH +: WIDTH], rr_ptr);
    end
    in_data = 8'h41;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 4'b0001 || out_data[0 +: WIDTH] !== 8'h41 || rr_ptr !== 2'd1) begin
      bad++; $display("FAIL ms_wrap got=%b/%h/%0d exp=0001/41/1", out_valid,
                      out_data[0 +: WIDTH], rr_ptr);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0;
    rr_en = 1'b0; out_ready = 4'b0000;
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_explicit();
    test_rr_wrap();
    test_back_pressure();
    test_independence();
    test_mode_switch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_stream_1x4.md
# demux_stream_1x4

Registered 1-to-4 stream demultiplexer: the routing inverse of the team's 4:1 selector. One input word stream with valid/ready handshake is steered to one of four output channels, each with a one-entry holding register and its own valid/ready handshake. The channel comes from an explicit select or from an internal round-robin pointer. It sits downstream of a shared bus and fans traffic out to four per-lane consumers.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input word
- in_sel  input  2  destination channel when rr_en=0
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word this cycle
- rr_en  input  1  1 = round-robin routing (in_sel ignored), 0 = explicit in_sel
- out_data  output  4*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- out_valid  output  4  per-channel word held
- out_ready  input  4  per-channel consumer accepts
- rr_ptr  output  2  current round-robin pointer

## Operation
- Target channel `t = rr_en ? rr_ptr : in_sel` (combinational).
- `in_ready = !out_valid[t] || out_ready[t]`. It is combinational from rr_en, in_sel, rr_ptr, out_valid and out_ready. It does not depend on in_valid.
- Accept: `in_valid && in_ready` at a rising edge. On accept, out_data slice t <= in_data and out_valid[t] <= 1.
- Drain: `out_valid[i] && out_ready[i]` at an edge. out_valid[i] <= 0 unless channel i is also accepted that edge; in that case it stays 1 and holds the new word.
- out_data slice i changes only on an accept to channel i. Data is held, unchanged, while out_valid[i]=1 and out_ready[i]=0.
- Non-target channels are unaffected by the input. Each drains independently in the same cycle.
- Round-robin pointer: on accept with rr_en=1, rr_ptr <= rr_ptr+1 mod 4 (3 wraps to 0). It does not advance without an accept.
- With rr_en=0, rr_ptr holds its value. Toggling rr_en does not reset it: round-robin resumes from the held value.
- A stalled round-robin target blocks input even if other channels are free. There is no skipping.
- in_data and in_sel are don't-care when in_valid=0. in_sel is ignored when rr_en=1.

## Timing
- Reset (rst=1 at an edge): out_valid=4'b0000, out_data=0, rr_ptr=0. in_ready is therefore 1 after reset.
- Reset mid-operation discards all held words, with no drain. Any input presented in the reset cycle is not accepted.
- Latency: word accepted at edge N is visible on out_data/out_valid after edge N.
- Throughput: one word per cycle sustained while the target channel's consumer holds out_ready=1, including back-to-back writes to the same channel (simultaneous drain+fill).
- Full per channel: out_valid[i]=1 and out_ready[i]=0 → in_ready=0 while t=i.

## Test plan
- Reset with out_valid nonzero: out_valid=0000, out_data=0, rr_ptr=0 after the reset edge; in_ready=1.
- Explicit mode: rr_en=0, out_ready=1111, words 0xA0..0xA3 with in_sel=0,1,2,3 on consecutive cycles → each appears on its channel one cycle later, with single-cycle out_valid pulses; rr_ptr stays 0.
- Round-robin wrap: rr_en=1, out_ready=1111, 6 words 0x10..0x15 → channels 0,1,2,3,0,1 receive them in order; rr_ptr ends at 2.
- Back-pressure: rr_en=0, in_sel=2, out_ready[2]=0, word 0x55 accepted → in_ready=0 next cycle. Word 0x66 is held off and 0x55 is held stable. Raise out_ready[2] → 0x66 is accepted in that same cycle (drain+fill) and out_valid[2] stays 1.
- Independence: channel 1 stalled holding 0x77 while writes to channels 0 and 3 proceed at full rate → 0x77 is unchanged and out_valid[1] stays 1.
- Mode switch: rr_en=1 with 3 accepts (rr_ptr=3), then rr_en=0 with 2 accepts, then rr_en=1 → the next word goes to channel 3, then the pointer wraps to 0.
